// File: rtl/serial_add_4b.sv
// Bit-serial adder: one full-adder slice processes one bit per clock, LSB first.
// Sum, carry-out and signed overflow are registered on the last bit and held until the next accepted start.
module serial_add_4b #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             c, s, c_nxt, last;

    assign s     = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last  = (cnt == CNT_W'(WIDTH-1));

    // New sum bit enters from the MSB side; after WIDTH shifts the LSB lands at bit 0.
    always_comb begin
        sum_nxt            = sum_sh >> 1;
        sum_nxt[WIDTH-1]   = s;
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            out    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        c      <= cin;
                        sum_sh <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= c_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        // On the MSB slice, c is the carry in and c_nxt the carry out.
                        out   <= sum_nxt;
                        cout  <= c_nxt;
                        ovf   <= c ^ c_nxt;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_add_4b.md
Name: serial_add_4b

Overview:
- Bit-serial, multi-cycle adder. It is the additive counterpart to the combinational 4-bit subtractor in the 4-bit operations library.
- Captures two WIDTH-bit operands plus carry-in on a start pulse, then adds one bit per clock, LSB first, through a single full-adder slice.
- Reports sum, carry-out and signed overflow with a one-cycle done strobe.
- Serves as the low-area add path for the integer ALU and as a sequential cross-check for the subtractor bench.

Parameters:
- WIDTH, 4, operand/result width in bits (must be >= 2).
- CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when the block can accept.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle strobe: result is valid.
- out  output  WIDTH  sum, registered, held until the next accepted start.
- cout  output  1  carry out of MSB, registered, held.
- ovf  output  1  two's-complement overflow, registered, held.

Behaviour:
- Reset (rst_n low at a rising edge): state goes to IDLE and all internal registers clear. busy=0, done=0, out=0, cout=0, ovf=0. Reset overrides any other input on the same edge.
- Reset mid-operation: the in-flight operation is abandoned. No done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1 at an edge, latch a, b and cin into shift registers, clear the bit counter, and go to RUN. busy rises after that edge.
- RUN: each edge performs the following.
  - Compute s = a_sh[0]^b_sh[0]^c and c_next = majority(a_sh[0], b_sh[0], c).
  - Shift s into the sum register from the MSB side.
  - Shift a_sh and b_sh right.
  - Increment the counter.
  - On the edge where counter == WIDTH-1, go to DONE and update out, cout and ovf in the same edge.
- ovf = carry into MSB XOR carry out of MSB, i.e. a[W-1]==b[W-1] and sum[W-1]!=a[W-1].
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Start in DONE is accepted (back-to-back). The FSM goes directly to RUN and re-latches the operands; the next done is WIDTH+1 cycles later.
- Latency: start accepted at edge k gives done high during the cycle after edge k+WIDTH, and low after edge k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy (RUN) is ignored. It is not queued, and the operands being processed are unaffected by changes on a, b or cin.
- out, cout and ovf change only on the final RUN edge. They remain stable through DONE and IDLE.
- Arithmetic is modulo 2**WIDTH; cout carries the bit WIDTH of a+b+cin.
- Width rule: sum register and out are exactly WIDTH bits, and no bit of the operands is sign-extended.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, out=0, cout=0, ovf=0; no operation starts.
- a=1, b=1, cin=0, start at edge k -> busy high for 4 cycles; done high after edge k+4; out=2, cout=0, ovf=0.
- a=7, b=15, cin=0 -> out=6, cout=1, ovf=0. Then a=15, b=0, cin=1 -> out=0, cout=1, ovf=0.
- Signed overflow: a=7, b=1, cin=0 -> out=8, cout=0, ovf=1. Then a=8, b=8 -> out=0, cout=1, ovf=1.
- Start pulsed again with a=3, b=3 two cycles after the first accepted start -> ignored; result matches the first operands. Next, start held during DONE -> second result done exactly 5 cycles later.
- Mid-run reset: start a=5, b=6, drop rst_n on the 2nd RUN edge -> no done strobe; outputs=0; IDLE; a fresh start then completes correctly with out=11.
